// File: rtl/sap1_alu_pkg.sv
// Shared encodings for the multi-op SAP1 ALU: operation codes and the
// sequential multiplier state encoding.
package sap1_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_ADC   = 4'd2;
    localparam logic [3:0] OP_SBC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_multi_if.sv
// Operand/result bundle between the register file, decoder and the ALU.
// Handshake: a MUL is accepted when i_start & i_op==OP_MUL is seen on an enabled
// edge while IDLE; o_busy covers the run and o_done marks one enabled cycle of valid product.
interface alu_multi_if #(parameter int WIDTH = 8);
    logic [3:0]       i_op;
    logic             i_start;
    logic             i_latch_flags;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] o_data_hi;
    logic             o_busy;
    logic             o_done;
    logic             o_zero;
    logic             o_carry;
    logic             o_odd;
    logic             o_neg;
    logic             o_ovf;
    logic [1:0]       o_dbg_state;

    modport master (
        output i_op, i_start, i_latch_flags, i_a, i_b,
        input  o_data, o_data_hi, o_busy, o_done,
               o_zero, o_carry, o_odd, o_neg, o_ovf, o_dbg_state
    );

    modport slave (
        input  i_op, i_start, i_latch_flags, i_a, i_b,
        output o_data, o_data_hi, o_busy, o_done,
               o_zero, o_carry, o_odd, o_neg, o_ovf, o_dbg_state
    );
endinterface

// File: rtl/alu_multi_mul_seq.sv
// Sequential shift-add multiplier: one partial product per enabled cycle,
// WIDTH steps, product left in {hi, lo} until the next start.
module alu_mul_seq
    import sap1_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_busy,
    output logic             o_done,
    output mul_state_t       o_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t       r_state;
    mul_state_t       w_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_sum;
    logic             w_last;

    // The multiplier register doubles as the product low half as bits shift in.
    assign w_sum  = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN:  if (w_last)  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state == ST_RUN);
        o_done  = (r_state == ST_DONE);
        o_state = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (clk_en) begin
            if (r_state == ST_IDLE && i_start) begin
                r_mcand  <= i_a;
                r_mplier <= i_b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == ST_RUN) begin
                r_acc    <= w_sum[WIDTH:1];
                r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_lo = r_mplier;
    assign o_hi = r_acc;

endmodule

// File: rtl/alu_multi.sv
// Multi-op ALU: combinational single-cycle ops, latched condition flags with
// carry chaining, and a sequential multiplier behind a start/busy/done handshake.
module alu_multi
    import sap1_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    alu_multi_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_busy;
    logic             w_done;
    mul_state_t       w_state;
    logic             w_mul_view;
    logic             w_mul_start;
    logic             r_zero;
    logic             r_carry;
    logic             r_odd;
    logic             r_neg;
    logic             r_ovf;

    always_comb begin
        w_ext       = '0;
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        case (bus.i_op)
            OP_ADD, OP_ADC: begin
                w_ext       = {1'b0, bus.i_a} + {1'b0, bus.i_b}
                            + {{WIDTH{1'b0}}, (bus.i_op == OP_ADC) & r_carry};
                w_alu_res   = w_ext[WIDTH-1:0];
                w_alu_carry = w_ext[WIDTH];
                w_alu_ovf   = (bus.i_a[MSB] == bus.i_b[MSB]) && (w_ext[MSB] != bus.i_a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the widened difference is the borrow.
                w_ext       = {1'b0, bus.i_a} - {1'b0, bus.i_b}
                            - {{WIDTH{1'b0}}, (bus.i_op == OP_SBC) & r_carry};
                w_alu_res   = w_ext[WIDTH-1:0];
                w_alu_carry = w_ext[WIDTH];
                w_alu_ovf   = (bus.i_a[MSB] != bus.i_b[MSB]) && (w_ext[MSB] != bus.i_a[MSB]);
            end
            OP_AND:   w_alu_res = bus.i_a & bus.i_b;
            OP_OR:    w_alu_res = bus.i_a | bus.i_b;
            OP_XOR:   w_alu_res = bus.i_a ^ bus.i_b;
            OP_NOT:   w_alu_res = ~bus.i_a;
            OP_SHL: begin
                w_alu_res   = {bus.i_a[WIDTH-2:0], 1'b0};
                w_alu_carry = bus.i_a[MSB];
            end
            OP_SHR: begin
                w_alu_res   = {1'b0, bus.i_a[WIDTH-1:1]};
                w_alu_carry = bus.i_a[0];
            end
            OP_PASSB: w_alu_res = bus.i_b;
            default:  w_alu_res = '0;
        endcase
    end

    assign w_mul_start = bus.i_start && (bus.i_op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .i_start (w_mul_start),
        .i_a     (bus.i_a),
        .i_b     (bus.i_b),
        .o_lo    (w_lo),
        .o_hi    (w_hi),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_state (w_state)
    );

    assign w_mul_view = (bus.i_op == OP_MUL) || w_busy || w_done;

    // MUL flags are taken in DONE regardless of inputs; single-cycle flags only from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_odd   <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clk_en) begin
            if (w_state == ST_DONE) begin
                r_zero  <= ({w_hi, w_lo} == '0);
                r_carry <= (w_hi != '0);
                r_odd   <= w_lo[0];
                r_neg   <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_state == ST_IDLE && bus.i_latch_flags && bus.i_op != OP_MUL) begin
                r_zero  <= (w_alu_res == '0);
                r_carry <= w_alu_carry;
                r_odd   <= w_alu_res[0];
                r_neg   <= w_alu_res[MSB];
                r_ovf   <= w_alu_ovf;
            end
        end
    end

    assign bus.o_data      = w_mul_view ? w_lo : w_alu_res;
    assign bus.o_data_hi   = w_mul_view ? w_hi : '0;
    assign bus.o_busy      = w_busy;
    assign bus.o_done      = w_done;
    assign bus.o_zero      = r_zero;
    assign bus.o_carry     = r_carry;
    assign bus.o_odd       = r_odd;
    assign bus.o_neg       = r_neg;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_dbg_state = w_state;

endmodule

// File: tb/tb_alu_multi.sv
// Bench for alu_multi at WIDTH=8: directed corner cases plus randomized ops
// against an integer-arithmetic reference model.
module tb_alu_multi;
  import sap1_alu_pkg::*;

  localparam int W = 8;
  localparam int M = 1 << W;
  localparam int H = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  logic m_zero = 1'b0, m_carry = 1'b0, m_odd = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_multi_if #(.WIDTH(W)) bus();

  alu_multi #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .bus(bus)
  );

  function automatic logic [4:0] dut_flags();
    return {bus.o_zero, bus.o_carry, bus.o_odd, bus.o_neg, bus.o_ovf};
  endfunction

  function automatic logic [4:0] mdl_flags();
    return {m_zero, m_carry, m_odd, m_neg, m_ovf};
  endfunction

  function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                  output int res, output bit c, output bit v);
    int t, sa, sb, st;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    t = 0; st = 0; c = 0; v = 0;
    case (op)
      OP_ADD:   begin t = a + b;       c = (t >= M); st = sa + sb;       v = (st >= H) || (st < -H); end
      OP_ADC:   begin t = a + b + cin; c = (t >= M); st = sa + sb + cin; v = (st >= H) || (st < -H); end
      OP_SUB:   begin t = a - b;       c = (t < 0);  st = sa - sb;       v = (st >= H) || (st < -H); end
      OP_SBC:   begin t = a - b - cin; c = (t < 0);  st = sa - sb - cin; v = (st >= H) || (st < -H); end
      OP_AND:   t = a & b;
      OP_OR:    t = a | b;
      OP_XOR:   t = a ^ b;
      OP_NOT:   t = ~a;
      OP_SHL:   begin t = a * 2; c = (a >= H); end
      OP_SHR:   begin t = a / 2; c = (a % 2) != 0; end
      OP_PASSB: t = b;
      default:  t = 0;
    endcase
    res = t & (M - 1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one MUL and gathers observations; the calling test judges them.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit toggle, input bit disturb,
                         output int busy_en, output int done_en,
                         output bit flags_moved, output bit timeout);
    bit seen;
    bus.i_op = OP_MUL; bus.i_a = a; bus.i_b = b;
    bus.i_start = 1'b1; bus.i_latch_flags = 1'b0; clk_en = 1'b1;
    tick();
    bus.i_start = 1'b0;
    busy_en = 0; done_en = 0; flags_moved = 0; timeout = 1; seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (toggle) clk_en = (i > 200) ? 1'b1 : 1'($urandom_range(0, 1));
      if (disturb && !seen) begin
        bus.i_op = OP_ADD; bus.i_start = 1'b1; bus.i_latch_flags = 1'b1;
        bus.i_a = W'($urandom); bus.i_b = W'($urandom);
      end
      @(negedge clk);
      if (bus.o_busy && dut_flags() != mdl_flags()) flags_moved = 1;
      if (bus.o_busy && clk_en) busy_en++;
      if (bus.o_done) begin
        if (clk_en) done_en++;
        seen = 1;
        bus.i_op = OP_MUL; bus.i_start = 1'b0; bus.i_latch_flags = 1'b0;
      end else if (seen) begin
        timeout = 0;
        break;
      end
      tick();
    end
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1;
    bus.i_op = OP_MUL; bus.i_start = 1'b0; bus.i_latch_flags = 1'b0;
    bus.i_a = '0; bus.i_b = '0;
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done: busy=%b done=%b required 0 0", bus.o_busy, bus.o_done);
    end
    n_tests++;
    if (dut_flags() !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000", dut_flags());
    end
    n_tests++;
    if (bus.o_data !== '0 || bus.o_data_hi !== '0) begin
      n_fail++; $display("FAIL reset_product: got %h%h required 0000", bus.o_data_hi, bus.o_data);
    end
    n_tests++;
    if (bus.o_dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", bus.o_dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_adc();
    bus.i_op = OP_ADD; bus.i_a = 8'hFF; bus.i_b = 8'h01; bus.i_latch_flags = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.o_data !== 8'h00) begin
      n_fail++; $display("FAIL add_data: got %h required 00", bus.o_data);
    end
    tick();
    bus.i_latch_flags = 1'b0;
    m_zero = 1; m_carry = 1; m_odd = 0; m_neg = 0; m_ovf = 0;
    n_tests++;
    if ({bus.o_zero, bus.o_carry, bus.o_ovf} !== 3'b110) begin
      n_fail++; $display("FAIL add_flags: zero/carry/ovf=%b required 110", {bus.o_zero, bus.o_carry, bus.o_ovf});
    end
    bus.i_op = OP_ADC; bus.i_a = 8'h00; bus.i_b = 8'h00;
    @(negedge clk);
    n_tests++;
    if (bus.o_data !== 8'h01) begin
      n_fail++; $display("FAIL adc_chain: got %h required 01", bus.o_data);
    end
    tick();
  endtask

  task automatic test_sub();
    bus.i_op = OP_SUB; bus.i_a = 8'h80; bus.i_b = 8'h01; bus.i_latch_flags = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.o_data !== 8'h7F) begin
      n_fail++; $display("FAIL sub_ovf_data: got %h required 7F", bus.o_data);
    end
    tick();
    m_zero = 0; m_carry = 0; m_odd = 1; m_neg = 0; m_ovf = 1;
    n_tests++;
    if ({bus.o_carry, bus.o_ovf, bus.o_neg} !== 3'b010) begin
      n_fail++; $display("FAIL sub_ovf_flags: carry/ovf/neg=%b required 010", {bus.o_carry, bus.o_ovf, bus.o_neg});
    end
    bus.i_a = 8'h01; bus.i_b = 8'h02;
    @(negedge clk);
    n_tests++;
    if (bus.o_data !== 8'hFF) begin
      n_fail++; $display("FAIL sub_borrow_data: got %h required FF", bus.o_data);
    end
    tick();
    bus.i_latch_flags = 1'b0;
    m_zero = 0; m_carry = 1; m_odd = 1; m_neg = 1; m_ovf = 0;
    n_tests++;
    if ({bus.o_carry, bus.o_neg} !== 2'b11) begin
      n_fail++; $display("FAIL sub_borrow_flags: carry/neg=%b required 11", {bus.o_carry, bus.o_neg});
    end
  endtask

  task automatic test_mul_basic();
    int be, de; bit fm, to;
    run_mul(8'h0F, 8'h11, 0, 0, be, de, fm, to);
    m_zero = 0; m_carry = 0; m_odd = 1; m_neg = 0; m_ovf = 0;
    n_tests++;
    if (to !== 1'b0 || be != 8 || de != 1) begin
      n_fail++; $display("FAIL mul_handshake: timeout=%b busy=%0d done=%0d required 0 8 1", to, be, de);
    end
    n_tests++;
    if ({bus.o_data_hi, bus.o_data} !== 16'h00FF) begin
      n_fail++; $display("FAIL mul_product: got %h%h required 00FF", bus.o_data_hi, bus.o_data);
    end
    n_tests++;
    if (dut_flags() !== mdl_flags()) begin
      n_fail++; $display("FAIL mul_flags: got %b required %b", dut_flags(), mdl_flags());
    end
  endtask

  task automatic test_mul_clken();
    int be, de; bit fm, to;
    run_mul(8'hFF, 8'hFF, 1, 0, be, de, fm, to);
    m_zero = 0; m_carry = 1; m_odd = 1; m_neg = 0; m_ovf = 0;
    n_tests++;
    if (to !== 1'b0 || be != 8 || de != 1) begin
      n_fail++; $display("FAIL mul_clken_handshake: timeout=%b busy=%0d done=%0d required 0 8 1", to, be, de);
    end
    n_tests++;
    if ({bus.o_data_hi, bus.o_data} !== 16'hFE01 || bus.o_carry !== 1'b1) begin
      n_fail++; $display("FAIL mul_clken_product: got %h%h carry %b required FE01 1",
                         bus.o_data_hi, bus.o_data, bus.o_carry);
    end
  endtask

  task automatic test_run_ignore();
    int be, de, p; bit fm, to;
    logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    p = int'(a) * int'(b);
    run_mul(a, b, 0, 1, be, de, fm, to);
    n_tests++;
    if (fm !== 1'b0) begin
      n_fail++; $display("FAIL run_ignore_flags: flags moved during RUN, required held at %b", mdl_flags());
    end
    m_zero = (p == 0); m_carry = (p >= M); m_odd = p[0]; m_neg = 0; m_ovf = 0;
    n_tests++;
    if (to !== 1'b0 || be != 8 || de != 1 || {bus.o_data_hi, bus.o_data} !== 16'(p)) begin
      n_fail++; $display("FAIL run_ignore_result: busy=%0d done=%0d prod=%h%h required 8 1 %h",
                         be, de, bus.o_data_hi, bus.o_data, 16'(p));
    end
    n_tests++;
    if (dut_flags() !== mdl_flags() || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL run_ignore_after: flags=%b busy=%b required %b 0", dut_flags(), bus.o_busy, mdl_flags());
    end
  endtask

  task automatic test_random_single();
    int op, a, b, res; bit c, v, lt, st;
    logic [W-1:0] e;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 10); a = $urandom_range(0, M - 1); b = $urandom_range(0, M - 1);
      lt = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
      bus.i_op = 4'(op); bus.i_a = W'(a); bus.i_b = W'(b);
      bus.i_latch_flags = lt; bus.i_start = st;
      ref_alu(op, a, b, int'(m_carry), res, c, v);
      exp_q.push_back(W'(res));
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (bus.o_data !== e || bus.o_data_hi !== '0) begin
        n_fail++; $display("FAIL rand_data op=%0d a=%h b=%h: got %h/%h required %h/00",
                           op, a, b, bus.o_data_hi, bus.o_data, e);
      end
      tick();
      if (lt) begin
        m_zero = (res == 0); m_odd = res[0]; m_neg = (res >= H); m_carry = c; m_ovf = v;
      end
      n_tests++;
      if (dut_flags() !== mdl_flags() || bus.o_busy !== 1'b0) begin
        n_fail++; $display("FAIL rand_flags op=%0d a=%h b=%h: flags=%b busy=%b required %b 0",
                           op, a, b, dut_flags(), bus.o_busy, mdl_flags());
      end
    end
    bus.i_start = 1'b0; bus.i_latch_flags = 1'b0;
  endtask

  task automatic test_random_mul();
    int be, de, p; bit fm, to;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom); b = (i == 0) ? '0 : W'($urandom);
      p = int'(a) * int'(b);
      run_mul(a, b, 1'(i % 2), 0, be, de, fm, to);
      m_zero = (p == 0); m_carry = (p >= M); m_odd = p[0]; m_neg = 0; m_ovf = 0;
      n_tests++;
      if (to !== 1'b0 || be != 8 || de != 1 || {bus.o_data_hi, bus.o_data} !== 16'(p)) begin
        n_fail++; $display("FAIL rand_mul %h*%h: busy=%0d done=%0d prod=%h%h required 8 1 %h",
                           a, b, be, de, bus.o_data_hi, bus.o_data, 16'(p));
      end
      n_tests++;
      if (dut_flags() !== mdl_flags()) begin
        n_fail++; $display("FAIL rand_mul_flags %h*%h: got %b required %b", a, b, dut_flags(), mdl_flags());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int be, de; bit fm, to, done_seen;
    bus.i_op = OP_MUL; bus.i_a = 8'h5A; bus.i_b = 8'h3C; bus.i_start = 1'b1; clk_en = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    done_seen = 0;
    n_tests++;
    if (bus.o_busy !== 1'b0 || bus.o_data !== '0 || bus.o_data_hi !== '0 || dut_flags() !== 5'b0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: busy=%b prod=%h%h flags=%b required 0 0000 00000",
                         bus.o_busy, bus.o_data_hi, bus.o_data, dut_flags());
    end
    n_tests++;
    if (bus.o_dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL midrun_reset_state: got %0d required %0d", bus.o_dbg_state, ST_IDLE);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 3) rst_n = 1'b1;
      @(negedge clk);
      if (bus.o_done) done_seen = 1;
    end
    n_tests++;
    if (done_seen !== 1'b0) begin
      n_fail++; $display("FAIL midrun_no_done: got done pulse, required none");
    end
    m_zero = 0; m_carry = 0; m_odd = 0; m_neg = 0; m_ovf = 0;
    run_mul(8'h5A, 8'h3C, 0, 0, be, de, fm, to);
    n_tests++;
    if (to !== 1'b0 || be != 8 || de != 1 || {bus.o_data_hi, bus.o_data} !== 16'h1518) begin
      n_fail++; $display("FAIL midrun_rerun: busy=%0d done=%0d prod=%h%h required 8 1 1518",
                         be, de, bus.o_data_hi, bus.o_data);
    end
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub();
    test_mul_basic();
    test_mul_clken();
    test_run_ignore();
    test_random_single();
    test_random_mul();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
